if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Fetch stage of the 5-stage pipelined RISC-V CPU: PC register, instruction-memory address
//  generation and IF/ID pipeline register. Sits upstream of decode/hazard detection, which
//  returns stall_i and flush_i. Runs only while start_i is high; holds a bubble otherwise.
// PARAMETERS
//  XLEN        32   datapath / PC width
//  IMEM_DEPTH  256  instruction memory words; fetches at or beyond IMEM_DEPTH*4 end the fetch stream
//  PC_RESET    0    PC value after reset
//  CNT_W       32   width of the performance counters (PERF_CNT_EN only)
// PORTS
//  clk_i            in   1     clock
//  rst_i            in   1     synchronous reset, active-high
//  start_i          in   1     1 = fetch enabled
//  stall_i          in   1     load-use stall from hazard detection: hold PC and IF/ID
//  flush_i          in   1     branch taken in ID: redirect PC, squash IF/ID
//  branch_target_i  in   XLEN  redirect address, valid with flush_i
//  imem_addr_o      out  XLEN  byte address to instruction memory (= pc_o)
//  imem_instr_i     in   32    instruction at imem_addr_o, same-cycle combinational read
//  pc_o             out  XLEN  current fetch PC
//  if_id_pc_o       out  XLEN  PC of the instruction held in IF/ID
//  if_id_instr_o    out  32    instruction held in IF/ID (bubble = 32'h0000_0000)
//  if_id_valid_o    out  1     IF/ID holds a real instruction
//  stall_cnt_o      out  CNT_W stalls counted (PERF_CNT_EN only)
//  flush_cnt_o      out  CNT_W flushes counted (PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset (synchronous, overrides all other inputs): pc_o = PC_RESET; if_id_pc_o = 0;
//    if_id_instr_o = 0; if_id_valid_o = 0; state = IDLE; counters = 0.
//  - FSM states: IDLE, RUN, END.
//    IDLE -> RUN when start_i = 1. RUN -> IDLE when start_i = 0.
//    RUN -> END when the next PC is >= IMEM_DEPTH*4. END -> RUN only on flush_i to an
//    in-range target. END -> IDLE when start_i = 0.
//  - IDLE/END: PC holds; IF/ID loads a bubble each cycle.
//  - RUN, per cycle, priority flush > stall > normal:
//    flush_i: pc <= {branch_target_i[XLEN-1:2],2'b00}; IF/ID <= bubble, valid 0.
//    stall_i (no flush): PC and all IF/ID fields hold their values.
//    normal: IF/ID <= {pc, imem_instr_i, valid 1}; pc <= pc + 4.
//  - Latency: an instruction at address A appears on if_id_* one cycle after pc_o = A.
//  - Flush and stall in the same cycle: flush wins. It is counted as a flush, not a stall.
//  - PC arithmetic is modulo 2^XLEN. Targets at or beyond IMEM_DEPTH*4 enter END on the next cycle.
//  - start_i falling in mid-stream: the fetch in flight is discarded (bubble); PC keeps its value.
// CONFIGURATION
//  PERF_CNT_EN defined: stall_cnt_o increments when state = RUN and stall_i & ~flush_i.
//    flush_cnt_o increments when state = RUN and flush_i. Both saturate at all-ones.
//  PERF_CNT_EN undefined: the counters and both output ports do not exist.
// STRUCTURE
//  - cpu_pkg: XLEN, INSTR_BUBBLE = 32'h0, fetch_state_t enum {IDLE,RUN,END}, if_id_t struct {pc,instr,valid}.
//  - One sub-module, if_id_reg: the IF/ID register with hold (stall) and clear (flush/bubble).
//    if_stage keeps the FSM, PC logic and counters.
// TESTING
//  1 reset, start_i=1, imem word0=32'h00500093 -> cycle 1: pc_o=4, if_id_instr_o=32'h00500093, valid=1
//  2 stall_i=1 for 2 cycles at pc=8 -> pc_o stays 8 and IF/ID is unchanged for 2 cycles;
//    stall_cnt_o=2 (with PERF_CNT_EN)
//  3 flush_i=1, branch_target_i=32'h20 at pc=12 -> next cycle: pc_o=32'h20, valid=0, instr=0;
//    the following cycle: if_id_pc_o=32'h20
//  4 flush_i and stall_i together, target=32'h40 -> pc_o=32'h40, bubble, flush_cnt_o+1, stall_cnt_o unchanged
//  5 IMEM_DEPTH=4, run from 0 -> after pc 12 fetches, state=END, pc_o=16 holds, bubbles follow;
//    flush to 32'h4 resumes RUN
//  6 rst_i=1 mid-stream with stall_i=1 -> next cycle: all outputs at reset values; target 32'h7 -> pc_o=32'h4

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: datapath width, bubble encoding, fetch FSM states
// and the IF/ID payload.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] INSTR_BUBBLE = 32'h0000_0000;

    typedef enum logic [1:0] {IDLE, RUN, END} fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: INSTR_BUBBLE, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear (bubble) beats hold, hold beats load.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   hold_i,
    input  logic   clear_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i)
            q_o <= IF_ID_BUBBLE;
        else if (!hold_i)
            q_o <= d_i;
    end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register, fetch FSM (IDLE/RUN/END) and IF/ID register.
// Optional stall/flush performance counters under `PERF_CNT_EN.
module if_stage #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 256,
    parameter logic [XLEN-1:0] PC_RESET   = '0
`ifdef PERF_CNT_EN
    ,
    parameter int              CNT_W      = 32
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [31:0]     if_id_instr_o,
    output logic            if_id_valid_o
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    import cpu_pkg::*;

    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_DEPTH * 4);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] target_al, pc_inc;
    logic            if_clear;
    if_id_t          fetch_d, if_id_q;
    logic            unused_tgt_lsb;

    assign target_al      = {branch_target_i[XLEN-1:2], 2'b00};
    assign pc_inc         = pc + XLEN'(4);
    assign unused_tgt_lsb = ^branch_target_i[1:0];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        unique case (state)
            // An out-of-range PC left behind by END must not be fetched on restart.
            IDLE: if (start_i) state_nxt = (pc < PC_LIMIT) ? RUN : END;
            RUN: begin
                if (!start_i) begin
                    state_nxt = IDLE;
                end else if (flush_i) begin
                    pc_nxt    = target_al;
                    state_nxt = (target_al < PC_LIMIT) ? RUN : END;
                end else if (!stall_i) begin
                    pc_nxt    = pc_inc;
                    state_nxt = (pc_inc < PC_LIMIT) ? RUN : END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_nxt = IDLE;
                end else if (flush_i && (target_al < PC_LIMIT)) begin
                    pc_nxt    = target_al;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            pc    <= PC_RESET;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Anything other than an active RUN cycle, or a redirect, squashes IF/ID.
    assign if_clear = !(state == RUN && start_i) || flush_i;
    assign fetch_d  = '{pc: pc, instr: imem_instr_i, valid: 1'b1};

    if_id_reg u_if_id (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .hold_i  (stall_i),
        .clear_i (if_clear),
        .d_i     (fetch_d),
        .q_o     (if_id_q)
    );

    assign imem_addr_o   = pc;
    assign pc_o          = pc;
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_valid_o = if_id_q.valid;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == RUN) begin
            if (flush_i && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
            else if (!flush_i && stall_i && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances (default depth and IMEM_DEPTH=4) driven by
// the same random stimulus, checked every cycle against a behavioural model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, start, stall, flush;
    logic [31:0] tgt;

    logic [31:0] addr_a, pc_a, ipc_a, ins_a, imem_a;
    logic [31:0] addr_b, pc_b, ipc_b, ins_b, imem_b;
    logic        vld_a, vld_b;
`ifdef PERF_CNT_EN
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif

    logic [31:0] mem [256];
    int npass = 0, ntot = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a < 32'd1024) return mem[a[9:2]];
        return 32'hdead_beef;
    endfunction

    assign imem_a = rd(addr_a);
    assign imem_b = rd(addr_b);

    if_stage dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
        .branch_target_i(tgt), .imem_addr_o(addr_a), .imem_instr_i(imem_a),
        .pc_o(pc_a), .if_id_pc_o(ipc_a), .if_id_instr_o(ins_a), .if_id_valid_o(vld_a)
`ifdef PERF_CNT_EN
        , .stall_cnt_o(sc_a), .flush_cnt_o(fc_a)
`endif
    );

    if_stage #(.IMEM_DEPTH(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
        .branch_target_i(tgt), .imem_addr_o(addr_b), .imem_instr_i(imem_b),
        .pc_o(pc_b), .if_id_pc_o(ipc_b), .if_id_instr_o(ins_b), .if_id_valid_o(vld_b)
`ifdef PERF_CNT_EN
        , .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Behavioural model: mode 0 = stopped, 1 = fetching, 2 = stream ended.
    int          m_mode [2];
    logic [31:0] m_pc [2], m_ipc [2], m_ins [2], m_sc [2], m_fc [2];
    logic        m_v [2];
    logic [31:0] lim [2] = '{32'd1024, 32'd16};
    bit          model_ok = 1'b0;

    task automatic bubble(input int i);
        m_ipc[i] = 0; m_ins[i] = 0; m_v[i] = 0;
    endtask

    task automatic step(input int i);
        logic [31:0] ta;
        ta = tgt & ~32'd3;
        if (rst) begin
            m_mode[i] = 0; m_pc[i] = 0; bubble(i); m_sc[i] = 0; m_fc[i] = 0;
            model_ok = 1'b1;
            return;
        end
        case (m_mode[i])
            0: begin
                bubble(i);
                if (start) m_mode[i] = (m_pc[i] < lim[i]) ? 1 : 2;
            end
            1: begin
                if (flush) begin
                    if (m_fc[i] != 32'hffff_ffff) m_fc[i]++;
                end else if (stall) begin
                    if (m_sc[i] != 32'hffff_ffff) m_sc[i]++;
                end
                if (!start) begin
                    bubble(i); m_mode[i] = 0;
                end else if (flush) begin
                    bubble(i); m_pc[i] = ta; m_mode[i] = (ta < lim[i]) ? 1 : 2;
                end else if (!stall) begin
                    m_ipc[i] = m_pc[i]; m_ins[i] = rd(m_pc[i]); m_v[i] = 1;
                    m_pc[i] = m_pc[i] + 4;
                    m_mode[i] = (m_pc[i] < lim[i]) ? 1 : 2;
                end
            end
            default: begin
                bubble(i);
                if (!start) m_mode[i] = 0;
                else if (flush && ta < lim[i]) begin m_pc[i] = ta; m_mode[i] = 1; end
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk);
            step(0);
            step(1);
            @(negedge clk);
            if (model_ok) begin
                chk("a.pc", pc_a, m_pc[0]);     chk("a.addr", addr_a, m_pc[0]);
                chk("a.ifpc", ipc_a, m_ipc[0]); chk("a.instr", ins_a, m_ins[0]);
                chk("a.valid", 32'(vld_a), 32'(m_v[0]));
                chk("b.pc", pc_b, m_pc[1]);     chk("b.ifpc", ipc_b, m_ipc[1]);
                chk("b.instr", ins_b, m_ins[1]);
                chk("b.valid", 32'(vld_b), 32'(m_v[1]));
`ifdef PERF_CNT_EN
                chk("a.stall_cnt", sc_a, m_sc[0]); chk("a.flush_cnt", fc_a, m_fc[0]);
                chk("b.stall_cnt", sc_b, m_sc[1]); chk("b.flush_cnt", fc_b, m_fc[1]);
`endif
            end
        end
    end

    task automatic drive(input bit r, input bit s, input bit st, input bit f, input logic [31:0] t);
        rst = r; start = s; stall = st; flush = f; tgt = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        mem[0] = 32'h0050_0093;
        rst = 1; start = 1; stall = 0; flush = 0; tgt = 0;

        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        chk("rst.pc", pc_a, 32'h0);    chk("rst.ifpc", ipc_a, 32'h0);
        chk("rst.instr", ins_a, 32'h0); chk("rst.valid", 32'(vld_a), 32'h0);

        drive(0, 1, 0, 0, 0);            // leave IDLE
        drive(0, 1, 0, 0, 0);            // first fetch at 0
        chk("t1.pc", pc_a, 32'h4); chk("t1.instr", ins_a, 32'h0050_0093);
        chk("t1.valid", 32'(vld_a), 32'h1);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        chk("t2.pc", pc_a, 32'h8); chk("t2.ifpc", ipc_a, 32'h4);
        chk("t2.instr", ins_a, mem[1]);
`ifdef PERF_CNT_EN
        chk("t2.stall_cnt", sc_a, 32'd2);
`endif
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 32'h20);
        chk("t3.pc", pc_a, 32'h20); chk("t3.valid", 32'(vld_a), 32'h0);
        chk("t3.instr", ins_a, 32'h0);
        drive(0, 1, 0, 0, 0);
        chk("t3.ifpc", ipc_a, 32'h20);
        drive(0, 1, 1, 1, 32'h40);
        chk("t4.pc", pc_a, 32'h40); chk("t4.valid", 32'(vld_a), 32'h0);
`ifdef PERF_CNT_EN
        chk("t4.flush_cnt", fc_a, 32'd2); chk("t4.stall_cnt", sc_a, 32'd2);
`endif

        drive(1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        repeat (4) drive(0, 1, 0, 0, 0);
        chk("t5.pc_end", pc_b, 32'd16); chk("t5.ifpc", ipc_b, 32'd12);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        chk("t5.pc_hold", pc_b, 32'd16); chk("t5.bubble", 32'(vld_b), 32'h0);
        drive(0, 1, 0, 1, 32'h4);
        chk("t5.redirect", pc_b, 32'h4);
        drive(0, 1, 0, 0, 0);
        chk("t5.resume", ipc_b, 32'h4); chk("t5.resume_v", 32'(vld_b), 32'h1);

        drive(0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0);
        chk("t6.pc", pc_a, 32'h0); chk("t6.valid", 32'(vld_a), 32'h0);
        chk("t6.ifpc", ipc_a, 32'h0); chk("t6.instr", ins_a, 32'h0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 32'h7);
        chk("t6.align", pc_a, 32'h4);

        repeat (3000) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1100));
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, t);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
